// File: rtl/cmp_arbiter_if.sv
// Request/response bundle between the requester side and the shared comparator arbiter.
//   req_valid/req_ready : per-requester handshake, req_ready one-hot or zero
//   req_a/req_b         : packed operands, requester i at [i*N +: N]
//   req_unsigned        : per-requester unsigned-compare select (only with CMP_ARB_UNSIGNED_EN)
//   rsp_*               : single result channel (valid/ready, id, eq, lt)
// Modports: master = requester/consumer side, slave = arbiter side.
interface cmp_arbiter_if #(
    parameter int unsigned N       = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) ();
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
`ifdef CMP_ARB_UNSIGNED_EN
    logic [NUM_REQ-1:0]   req_unsigned;
`endif
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_eq;
    logic                 rsp_lt;

    modport master (
`ifdef CMP_ARB_UNSIGNED_EN
        output req_unsigned,
`endif
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt
    );

    modport slave (
`ifdef CMP_ARB_UNSIGNED_EN
        input  req_unsigned,
`endif
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_eq, rsp_lt
    );
endinterface

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter sharing one equality + less-than comparator among NUM_REQ requesters.
// One request in flight: IDLE (grant) -> EVAL (compare) -> RESP (hold result until accepted).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : cmp_arbiter_if.slave (request handshake, operands, response channel)
// Optional feature macro: CMP_ARB_UNSIGNED_EN adds per-requester unsigned less-than select.
module cmp_arbiter #(
    parameter int unsigned N       = 32,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic          clk,
    input  logic          rst_n,
    cmp_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e          state_q;
    logic [ID_W-1:0] rr_ptr_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [ID_W-1:0] id_q;
`ifdef CMP_ARB_UNSIGNED_EN
    logic            uns_q;
`endif
    logic            rsp_valid_q;
    logic [ID_W-1:0] rsp_id_q;
    logic            rsp_eq_q;
    logic            rsp_lt_q;

    logic               found;
    logic [ID_W-1:0]    win;
    logic [NUM_REQ-1:0] grant;
    logic [N-1:0]       sel_a;
    logic [N-1:0]       sel_b;
    logic               hs;
    logic [ID_W-1:0]    next_ptr;
    logic               eq_res;
    logic               lt_res;

    // Rotating priority search: first valid requester at or after rr_ptr, modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && bus.req_valid[ID_W'(idx)]) begin
                found = 1'b1;
                win   = ID_W'(idx);
            end
        end
    end

    // Operand mux for the current winner.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (ID_W'(i) == win) begin
                sel_a = bus.req_a[i*N +: N];
                sel_b = bus.req_b[i*N +: N];
            end
        end
    end

    // Grant only offered in IDLE and never while reset is asserted.
    assign grant         = (rst_n && state_q == IDLE && found) ? (NUM_REQ'(1) << win) : '0;
    assign bus.req_ready = grant;
    assign hs            = |(bus.req_valid & grant);
    assign next_ptr      = (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);

    // Direct magnitude compares, no subtract-and-sign so no overflow corner.
    assign eq_res = (a_q == b_q);
`ifdef CMP_ARB_UNSIGNED_EN
    assign lt_res = uns_q ? (a_q < b_q) : ($signed(a_q) < $signed(b_q));
`else
    assign lt_res = $signed(a_q) < $signed(b_q);
`endif

    // Control FSM and registered result channel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
`ifdef CMP_ARB_UNSIGNED_EN
            uns_q       <= 1'b0;
`endif
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_eq_q    <= 1'b0;
            rsp_lt_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        id_q     <= win;
`ifdef CMP_ARB_UNSIGNED_EN
                        uns_q    <= bus.req_unsigned[win];
`endif
                        rr_ptr_q <= next_ptr;
                        state_q  <= EVAL;
                    end
                end
                EVAL: begin
                    rsp_eq_q    <= eq_res;
                    rsp_lt_q    <= lt_res;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_valid_q && bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_eq    = rsp_eq_q;
    assign bus.rsp_lt    = rsp_lt_q;

endmodule
